// File: rtl/param_shift_engine.sv
// param_shift_engine: WIDTH-bit register with parallel load, a legacy
// single-step left shift, and a multi-cycle shift engine. The engine supports
// left/right direction, logical/arithmetic/rotate/serial-fill modes and a
// variable step count, with a start/busy/done handshake.
module param_shift_engine #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             shift,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] MODE_LOG = 2'b00;
  localparam logic [1:0] MODE_ARI = 2'b01;
  localparam logic [1:0] MODE_ROT = 2'b10;
  localparam logic [1:0] MODE_SER = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             dir_q;
  logic [1:0]       mode_q;
  logic [WIDTH:0]   step_res;

  // One single-bit step: returns {ejected bit, new register value}.
  // The vacated end is filled according to mode; the arithmetic right fill
  // is the sign bit of the signed view of the register.
  function automatic logic [WIDTH:0] shift_step(
    input logic [WIDTH-1:0] d,
    input logic             right,
    input logic [1:0]       md,
    input logic             sin
  );
    logic signed [WIDTH-1:0] sd;
    logic                    ej;
    logic                    fill;
    logic [WIDTH-1:0]        nd;
    sd = d;
    ej = right ? d[0] : d[WIDTH-1];
    case (md)
      MODE_ROT: fill = ej;
      MODE_SER: fill = sin;
      MODE_ARI: fill = right ? sd[WIDTH-1] : 1'b0;
      MODE_LOG: fill = 1'b0;
      default:  fill = 1'b0;
    endcase
    if (right) nd = {fill, d[WIDTH-1:1]};
    else       nd = {d[WIDTH-2:0], fill};
    return {ej, nd};
  endfunction

  // Next-step candidate from the latched direction/mode and the live fill bit.
  always_comb begin
    step_res = shift_step(data_out, dir_q, mode_q, serial_in);
  end

  // Control FSM and register update; reset clears everything at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      dir_q      <= 1'b0;
      mode_q     <= MODE_LOG;
      data_out   <= '0;
      serial_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (load) begin
            data_out <= data_in;
          end else if (start) begin
            dir_q  <= dir;
            mode_q <= mode;
            cnt    <= amount;
            if (amount != '0) begin
              state <= ST_SHIFT;
              busy  <= 1'b1;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end else if (shift) begin
            data_out   <= {data_out[WIDTH-2:0], 1'b0};
            serial_out <= data_out[WIDTH-1];
          end
        end
        ST_SHIFT: begin
          data_out   <= step_res[WIDTH-1:0];
          serial_out <= step_res[WIDTH];
          cnt        <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
